char_rom_arb: RTL and testbench

Round-robin arbiter and row extractor that shares the single character ROM between two glyph requesters (e.g. score/level text and playfield label overlay). Each cycle it grants at most one requester and drives the ROM address. It tracks the request through the ROM's registered read latency, then returns the selected 8-pixel glyph row to the requester that issued it. It sits between the video-timing/text layers and the character ROM, and is fully pipelined: one lookup per cycle sustained.

---
 rtl/char_rom_arb.sv | 133 +++++++++++++
 tb/tb_char_rom_arb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/char_rom_arb.sv
// char_rom_arb: round-robin share of one character ROM between two glyph
// requesters. It issues the ROM address and carries a {valid,id,row} tag
// through the ROM read latency. It then extracts the requested 8-pixel row
// and returns it to the requester that asked for it.
module char_rom_arb #(
  parameter int ROM_LAT = 1,
  parameter bit MIRROR  = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_res,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [5:0]  i_code0,
  input  logic [5:0]  i_code1,
  input  logic [2:0]  i_row0,
  input  logic [2:0]  i_row1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic        o_vld0,
  output logic        o_vld1,
  output logic [7:0]  o_pix,
  output logic [5:0]  o_rom_addr,
  input  logic [63:0] i_rom_data,
  output logic        o_busy
);

  typedef enum logic {LAST_0 = 1'b0, LAST_1 = 1'b1} last_e;

  typedef struct packed {
    logic       vld;
    logic       id;
    logic [2:0] row;
  } tag_t;

  last_e      last_q, last_d;
  logic [5:0] rom_addr_q, rom_addr_d;
  tag_t       iss_q, iss_d;
  tag_t       dly_q [ROM_LAT];
  logic [7:0] pix_q, pix_d;
  logic       vld0_q, vld0_d;
  logic       vld1_q, vld1_d;
  logic       gnt0, gnt1;
  tag_t       al_tag;
  logic [7:0] row_bits;
  logic [7:0] row_rev;
  logic       busy;

  // Arbitration: a lone requester wins; a tie goes to the one not granted last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_res) begin
      if (i_req0 && (!i_req1 || last_q == LAST_1)) gnt0 = 1'b1;
      else if (i_req1)                             gnt1 = 1'b1;
    end
  end

  // Next pointer, issue address and issue tag from the granted requester.
  always_comb begin
    last_d     = last_q;
    rom_addr_d = rom_addr_q;
    iss_d      = '0;
    if (gnt0) begin
      last_d     = LAST_0;
      rom_addr_d = i_code0;
      iss_d      = '{vld: 1'b1, id: 1'b0, row: i_row0};
    end else if (gnt1) begin
      last_d     = LAST_1;
      rom_addr_d = i_code1;
      iss_d      = '{vld: 1'b1, id: 1'b1, row: i_row1};
    end
  end

  // Row extraction from the ROM word that lines up with the oldest tag.
  always_comb begin
    al_tag   = dly_q[ROM_LAT-1];
    row_bits = i_rom_data[{~al_tag.row, 3'b000} +: 8];
    row_rev  = '0;
    for (int unsigned i = 0; i < 8; i++) row_rev[i] = row_bits[7-i];
    pix_d  = pix_q;
    vld0_d = 1'b0;
    vld1_d = 1'b0;
    if (al_tag.vld) begin
      pix_d  = MIRROR ? row_rev : row_bits;
      vld0_d = ~al_tag.id;
      vld1_d = al_tag.id;
    end
  end

  // Busy whenever any pipeline stage holds a valid lookup.
  always_comb begin
    busy = iss_q.vld | vld0_q | vld1_q;
    for (int unsigned i = 0; i < ROM_LAT; i++) busy = busy | dly_q[i].vld;
  end

  // Pointer, issue stage and extract stage registers.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      last_q     <= LAST_1;
      rom_addr_q <= '0;
      iss_q      <= '0;
      pix_q      <= '0;
      vld0_q     <= 1'b0;
      vld1_q     <= 1'b0;
    end else begin
      last_q     <= last_d;
      rom_addr_q <= rom_addr_d;
      iss_q      <= iss_d;
      pix_q      <= pix_d;
      vld0_q     <= vld0_d;
      vld1_q     <= vld1_d;
    end
  end

  // Tag delay line matching the ROM read latency.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      for (int unsigned i = 0; i < ROM_LAT; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= iss_q;
      for (int unsigned i = 1; i < ROM_LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign o_gnt0     = gnt0;
  assign o_gnt1     = gnt1;
  assign o_vld0     = vld0_q;
  assign o_vld1     = vld1_q;
  assign o_pix      = pix_q;
  assign o_rom_addr = rom_addr_q;
  assign o_busy     = busy;

endmodule

// File: tb/tb_char_rom_arb.sv
// Bench for char_rom_arb: four builds (latency 1/2/1/4, mirror off/off/on/on)
// share one stimulus stream. Each build has its own ROM model, arbiter model
// and result scoreboard.
module tb_char_rom_arb;

  typedef struct {
    bit         id;
    logic [7:0] pix;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       res;
  logic       req0, req1;
  logic [5:0] code0, code1;
  logic [2:0] row0, row1;
  bit         mon_on = 1'b0;
  bit         done   = 1'b0;
  int         cyc    = 0;
  int         n_chk  = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference glyph words (row 0 in the top byte); codes above 42 read as blank.
  function automatic logic [63:0] glyph(input logic [5:0] c);
    case (c)
      6'd0:    glyph = 64'h708898A8C8887000;
      6'd1:    glyph = 64'h2060202020207000;
      6'd8:    glyph = 64'h7088887088887000;
      6'd17:   glyph = 64'h888888F888888800;
      6'd21:   glyph = 64'h808080808080F800;
      default: glyph = (c <= 6'd42) ? {8{c, 2'b10}} : 64'h0;
    endcase
  endfunction

  function automatic logic [7:0] exp_pix(input logic [5:0] c, input logic [2:0] r, input bit mir);
    logic [63:0] w;
    logic [7:0]  b;
    w = glyph(c) >> (56 - 8 * int'(r));
    b = w[7:0];
    exp_pix = mir ? {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]} : b;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int LAT = (g == 1) ? 2 : (g == 3) ? 4 : 1;
    localparam bit MIR = (g >= 2);

    logic        gnt0, gnt1, vld0, vld1, busy;
    logic [7:0]  pix;
    logic [5:0]  addr;
    logic [63:0] rom_data;
    logic [63:0] rom_pipe [LAT];

    exp_t       q[$];
    exp_t       e;
    bit         m_last = 1'b1;
    logic [7:0] m_pix  = 8'h00;
    logic [5:0] m_addr = 6'h00;
    bit         eb, eg0, eg1, closed = 1'b0;
    string      pfx;

    char_rom_arb #(.ROM_LAT(LAT), .MIRROR(MIR)) u_dut (
      .i_clk      (clk),
      .i_res      (res),
      .i_req0     (req0),
      .i_req1     (req1),
      .i_code0    (code0),
      .i_code1    (code1),
      .i_row0     (row0),
      .i_row1     (row1),
      .o_gnt0     (gnt0),
      .o_gnt1     (gnt1),
      .o_vld0     (vld0),
      .o_vld1     (vld1),
      .o_pix      (pix),
      .o_rom_addr (addr),
      .i_rom_data (rom_data),
      .o_busy     (busy)
    );

    // Registered ROM with LAT cycles from address edge to data.
    always @(posedge clk) begin
      rom_pipe[0] <= glyph(addr);
      for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign rom_data = rom_pipe[LAT-1];

    always @(negedge clk) begin
      if (mon_on) begin
        pfx = $sformatf("lat%0d/mir%0d", LAT, MIR);
        eb = 1'b0;
        foreach (q[i]) if (q[i].due - LAT - 2 < cyc) eb = 1'b1;
        check({pfx, " busy"}, busy, eb);
        if (vld0 || vld1) begin
          if (q.size() == 0) begin
            check({pfx, " spurious vld"}, {vld1, vld0}, 2'b00);
          end else begin
            e = q.pop_front();
            check({pfx, " vld id"}, {vld1, vld0}, e.id ? 2'b10 : 2'b01);
            check({pfx, " latency"}, cyc, e.due);
            m_pix = e.pix;
          end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
          e = q.pop_front();
          check({pfx, " missing vld"}, {vld1, vld0}, e.id ? 2'b10 : 2'b01);
        end
        check({pfx, " pix"}, pix, m_pix);
        check({pfx, " rom_addr"}, addr, m_addr);
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (!res) begin
          if (req0 && (!req1 || m_last)) eg0 = 1'b1;
          else if (req1)                 eg1 = 1'b1;
        end
        check({pfx, " gnt"}, {gnt1, gnt0}, {eg1, eg0});
        if (res) begin
          q.delete();
          m_last = 1'b1;
          m_pix  = 8'h00;
          m_addr = 6'h00;
        end else if (eg0 || eg1) begin
          m_last = eg1;
          m_addr = eg1 ? code1 : code0;
          q.push_back('{id: eg1,
                        pix: eg1 ? exp_pix(code1, row1, MIR) : exp_pix(code0, row0, MIR),
                        due: cyc + LAT + 2});
        end
        if (done && !closed) begin
          check({pfx, " drained"}, q.size(), 0);
          closed = 1'b1;
        end
      end
    end
  end

  task automatic drive(input logic r0, input logic [5:0] c0, input logic [2:0] w0,
                       input logic r1, input logic [5:0] c1, input logic [2:0] w1,
                       input logic rs);
    req0  = r0;
    code0 = c0;
    row0  = w0;
    req1  = r1;
    code1 = c1;
    row1  = w1;
    res   = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 6'd0, 3'd0, 1'b0, 6'd0, 3'd0, 1'b0);
  endtask

  initial begin
    res = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    code0 = '0; code1 = '0; row0 = '0; row1 = '0;
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    drive(1'b1, 6'd3, 3'd1, 1'b1, 6'd4, 3'd2, 1'b1);
    drive(1'b0, 6'd0, 3'd0, 1'b0, 6'd0, 3'd0, 1'b1);
    idle(2);
    // single lookup
    drive(1'b1, 6'd1, 3'd0, 1'b0, 6'd0, 3'd0, 1'b0);
    idle(7);
    // tie fairness
    for (int i = 0; i < 8; i++) drive(1'b1, 6'd0, 3'd3, 1'b1, 6'd8, 3'd3, 1'b0);
    idle(7);
    // back-to-back rows of 'H' from requester 1
    for (int r = 0; r < 8; r++) drive(1'b0, 6'd0, 3'd0, 1'b1, 6'd17, 3'(r), 1'b0);
    idle(7);
    // 'L' row 6 and an out-of-range code
    drive(1'b1, 6'd21, 3'd6, 1'b0, 6'd0, 3'd0, 1'b0);
    drive(1'b1, 6'd63, 3'd2, 1'b0, 6'd0, 3'd0, 1'b0);
    idle(7);
    // random traffic
    for (int i = 0; i < 60; i++)
      drive(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)), 1'b0);
    idle(7);
    // reset with lookups in flight; last grant before reset was requester 0
    drive(1'b0, 6'd0, 3'd0, 1'b1, 6'd8, 3'd1, 1'b0);
    drive(1'b1, 6'd1, 3'd2, 1'b0, 6'd0, 3'd0, 1'b0);
    drive(1'b1, 6'd5, 3'd0, 1'b1, 6'd9, 3'd4, 1'b1);
    drive(1'b1, 6'd5, 3'd0, 1'b1, 6'd9, 3'd4, 1'b0);
    drive(1'b1, 6'd0, 3'd7, 1'b1, 6'd17, 3'd3, 1'b0);
    idle(10);
    done = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
